adc_dual_capture: RTL and testbench

Capture controller running in the 20 MHz sample clock domain produced by the board PLL (50 MHz in, 800 MHz VCO, /40). It qualifies the PLL lock output, keeps both ADC channels powered down until the clock is stable, then captures fixed-length frames of paired channel A/B samples. Capture runs free or on a level-crossing trigger. Frames are presented on a valid/ready stream to the downstream buffer/transport stage.

---
 rtl/adc_dual_capture.sv | 205 ++++++++++++++++++++
 tb/tb_adc_dual_capture.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_dual_capture.sv
// adc_dual_capture: PLL-lock qualified dual-channel ADC frame capture with an
// optional rising-level trigger and a single-register valid/ready output stage.
//
// state     | meaning
// WAIT_LOCK | ADC powered down, waiting for synchronised PLL lock
// SETTLE    | ADC powered, letting the sample clock settle
// IDLE      | waiting for a start request
// ARMED     | waiting for a rising crossing of the trigger level on channel A
// CAPTURE   | producing one paired sample per cycle
// DONE      | letting the last word leave before signalling completion
module adc_dual_capture #(
    parameter int ADC_WIDTH     = 12,
    parameter int FRAME_LEN     = 256,
    parameter int SETTLE_CYCLES = 1024
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pll_lock,
    input  logic [ADC_WIDTH-1:0]   adc_a_data,
    input  logic [ADC_WIDTH-1:0]   adc_b_data,
    output logic                   adc_pwdn,
    input  logic                   start,
    input  logic                   trig_en,
    input  logic [ADC_WIDTH-1:0]   trig_level,
    output logic                   ready,
    output logic [2*ADC_WIDTH-1:0] out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_last,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam logic [15:0] FRAME_LAST  = 16'(FRAME_LEN - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_WAIT_LOCK,
        S_SETTLE,
        S_IDLE,
        S_ARMED,
        S_CAPTURE,
        S_DONE
    } state_t;

    state_t state, next_state;

    logic                 lock_m, lock_s;
    logic [ADC_WIDTH-1:0] a_r, b_r, a_prev;
    logic [ADC_WIDTH-1:0] trig_lvl_r;
    logic [15:0]          settle_cnt;
    logic [15:0]          sample_cnt;

    logic produce, is_last, start_acc, settle_clr, done_fire, lock_lost, load_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r    <= '0;
            b_r    <= '0;
            a_prev <= '0;
        end else begin
            a_r    <= adc_a_data;
            b_r    <= adc_b_data;
            a_prev <= a_r;
        end
    end

    assign lock_lost = (state != S_WAIT_LOCK) && !lock_s;
    assign load_ok   = !out_valid || out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_WAIT_LOCK;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        produce    = 1'b0;
        is_last    = 1'b0;
        start_acc  = 1'b0;
        settle_clr = 1'b0;
        done_fire  = 1'b0;
        if (lock_lost) begin
            next_state = S_WAIT_LOCK;
        end else begin
            case (state)
                S_WAIT_LOCK: begin
                    if (lock_s) begin
                        settle_clr = 1'b1;
                        next_state = S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        next_state = S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (start) begin
                        start_acc  = 1'b1;
                        next_state = trig_en ? S_ARMED : S_CAPTURE;
                    end
                end
                S_ARMED: begin
                    // the crossing sample itself is sample 0 of the frame
                    if ((a_prev < trig_lvl_r) && (a_r >= trig_lvl_r)) begin
                        produce    = 1'b1;
                        next_state = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    produce = 1'b1;
                    if (sample_cnt == FRAME_LAST) begin
                        is_last    = 1'b1;
                        next_state = S_DONE;
                    end
                end
                S_DONE: begin
                    if (load_ok) begin
                        done_fire  = 1'b1;
                        next_state = S_IDLE;
                    end
                end
                default: next_state = S_WAIT_LOCK;
            endcase
        end
    end

    // Status outputs are registered from the next state so they never glitch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            adc_pwdn <= 1'b1;
            ready    <= 1'b0;
        end else begin
            adc_pwdn <= (next_state == S_WAIT_LOCK);
            ready    <= (next_state == S_IDLE);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            sample_cnt <= '0;
            trig_lvl_r <= '0;
        end else begin
            if (settle_clr) begin
                settle_cnt <= '0;
            end else if (state == S_SETTLE) begin
                settle_cnt <= settle_cnt + 16'd1;
            end
            if (start_acc) begin
                sample_cnt <= '0;
                trig_lvl_r <= trig_level;
            end else if (produce) begin
                sample_cnt <= sample_cnt + 16'd1;
            end
        end
    end

    // Frame length is time based: a sample that cannot be loaded is dropped
    // but still counted, and flags overrun for the rest of the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data   <= '0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            overrun    <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= done_fire;
            if (lock_lost) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end else if (produce) begin
                if (load_ok) begin
                    out_data  <= {b_r, a_r};
                    out_last  <= is_last;
                    out_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
            if (start_acc) begin
                overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_adc_dual_capture.sv
// Bench for adc_dual_capture: lock sequencing, trigger vector table, free-run
// frames against a frame-level reference model, backpressure, lock loss, reset.
module tb_adc_dual_capture;

    localparam int W  = 12;
    localparam int FL = 256;
    localparam int SC = 1024;

    logic           clk = 1'b0;
    logic           rst, pll_lock, start, trig_en, out_ready;
    logic [W-1:0]   adc_a_data, adc_b_data, trig_level;
    logic           adc_pwdn, ready, out_valid, out_last, frame_done, overrun;
    logic [2*W-1:0] out_data;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int xfers  = 0;

    logic [W-1:0] pa [0:511];
    logic [W-1:0] pb [0:511];
    bit           rdy_pat [0:511];

    logic [2*W-1:0] exp_d [$];
    bit             exp_l [$];

    typedef struct {
        logic [W-1:0] pre;
        logic [W-1:0] cur;
        logic [W-1:0] lvl;
        logic [W-1:0] bval;
        bit           fire;
    } trig_vec_t;
    trig_vec_t tv [7];

    adc_dual_capture #(.ADC_WIDTH(W), .FRAME_LEN(FL), .SETTLE_CYCLES(SC)) dut (
        .clk(clk), .rst(rst), .pll_lock(pll_lock),
        .adc_a_data(adc_a_data), .adc_b_data(adc_b_data), .adc_pwdn(adc_pwdn),
        .start(start), .trig_en(trig_en), .trig_level(trig_level), .ready(ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .frame_done(frame_done), .overrun(overrun)
    );

    always #25 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (out_valid && out_ready) xfers++;
    endtask

    function automatic int first_ready(input int from);
        for (int c = from; c < 512; c++) if (rdy_pat[c]) return c;
        return 511;
    endfunction

    // Sample i is the pin value of cycle start+i and becomes visible at rel 2+i;
    // it survives only if the word ahead of it has left by the preceding cycle.
    task automatic build_model(output int fd_rel, output bit ovr);
        int taken;
        exp_d.delete();
        exp_l.delete();
        ovr   = 1'b0;
        taken = -1;
        for (int i = 0; i < FL; i++) begin
            if (taken <= i + 1) begin
                exp_d.push_back({pb[i], pa[i]});
                exp_l.push_back(i == FL - 1);
                taken = first_ready(i + 2);
            end else begin
                ovr = 1'b1;
            end
        end
        fd_rel = first_ready(FL + 1) + 1;
    endtask

    task automatic run_frame(input string tag, input int mid_start, output int n_words,
                             output int fd_obs, output bit ovr_obs);
        int fd_exp, fd_cnt, idx;
        bit ovr_exp, prev_hold;
        logic [2*W-1:0] prev_d;
        build_model(fd_exp, ovr_exp);
        idx = 0; fd_cnt = 0; fd_obs = -1; prev_hold = 1'b0; prev_d = '0;
        start = 1'b1; trig_en = 1'b0; out_ready = rdy_pat[0];
        adc_a_data = pa[0]; adc_b_data = pb[0];
        for (int rel = 1; rel < 500; rel++) begin
            tick();
            start      = (rel == mid_start);
            trig_en    = (rel == mid_start) && rel[0];
            out_ready  = rdy_pat[rel];
            adc_a_data = pa[rel];
            adc_b_data = pb[rel];
            if (prev_hold) check({tag, " hold"}, out_data, prev_d);
            prev_hold = out_valid && !out_ready;
            prev_d    = out_data;
            if (out_valid && out_ready) begin
                if (idx < exp_d.size()) begin
                    check($sformatf("%s word%0d", tag, idx), out_data, exp_d[idx]);
                    check($sformatf("%s last%0d", tag, idx), out_last, exp_l[idx]);
                end else begin
                    check({tag, " extra_word"}, idx, exp_d.size());
                end
                idx++;
            end
            if (frame_done) begin
                fd_cnt++;
                if (fd_obs < 0) fd_obs = rel;
            end
            if (fd_obs >= 0 && rel >= fd_obs + 3) break;
        end
        start = 1'b0;
        check({tag, " word_count"}, idx, exp_d.size());
        check({tag, " done_cycle"}, fd_obs, fd_exp);
        check({tag, " done_pulses"}, fd_cnt, 1);
        check({tag, " overrun"}, overrun, ovr_exp);
        check({tag, " ready_after"}, ready, 1);
        n_words = idx;
        ovr_obs = overrun;
    endtask

    task automatic lock_sequence(input string tag);
        int pw_at, rd_cnt;
        pw_at = -1; rd_cnt = -1;
        pll_lock = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (!adc_pwdn) begin pw_at = i; break; end
        end
        check({tag, " pwdn_within_3"}, (pw_at >= 1) && (pw_at <= 3), 1);
        for (int i = 1; i <= SC + 10; i++) begin
            tick();
            if (ready) begin rd_cnt = i; break; end
        end
        check({tag, " settle_cycles"}, rd_cnt, SC);
        check({tag, " pwdn_in_idle"}, adc_pwdn, 0);
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 400; i++) begin
            tick();
            if (frame_done) begin seen = 1'b1; break; end
        end
        check({tag, " frame_done_seen"}, seen, 1);
    endtask

    task automatic trig_row(input int r);
        int seen;
        logic [2*W-1:0] first;
        string tag;
        tag = $sformatf("trig%0d", r);
        seen = -1; first = '0;
        out_ready = 1'b1;
        adc_a_data = tv[r].pre; adc_b_data = tv[r].bval;
        repeat (3) tick();
        xfers = 0;
        trig_level = tv[r].lvl; trig_en = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; trig_en = 1'b0; trig_level = ~tv[r].lvl;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check({tag, " armed_quiet"}, {ready, out_valid}, 2'b00);
        adc_a_data = tv[r].cur;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid && seen < 0) begin seen = i; first = out_data; end
        end
        check({tag, " fired"}, seen >= 0, tv[r].fire);
        if (tv[r].fire) begin
            check({tag, " first_word"}, first, {tv[r].bval, tv[r].cur});
        end else begin
            adc_a_data = '0;
            repeat (2) tick();
            adc_a_data = '1;
        end
        wait_done(tag);
        repeat (2) tick();
        check({tag, " words"}, xfers, FL);
    endtask

    initial begin
        int n, fd, pct, base, act;
        bit ov;

        tv[0] = '{pre: 12'h7FF, cur: 12'h800, lvl: 12'h800, bval: 12'h123, fire: 1'b1};
        tv[1] = '{pre: 12'h900, cur: 12'h900, lvl: 12'h800, bval: 12'h456, fire: 1'b0};
        tv[2] = '{pre: 12'h7FF, cur: 12'h7FF, lvl: 12'h800, bval: 12'h789, fire: 1'b0};
        tv[3] = '{pre: 12'h000, cur: 12'hFFF, lvl: 12'hFFF, bval: 12'hABC, fire: 1'b1};
        tv[4] = '{pre: 12'h800, cur: 12'h801, lvl: 12'h800, bval: 12'h0F0, fire: 1'b0};
        tv[5] = '{pre: 12'h000, cur: 12'h001, lvl: 12'h001, bval: 12'hF0F, fire: 1'b1};
        tv[6] = '{pre: 12'h900, cur: 12'h100, lvl: 12'h800, bval: 12'h555, fire: 1'b0};

        rst = 1'b1; pll_lock = 1'b0; start = 1'b0; trig_en = 1'b0; out_ready = 1'b0;
        adc_a_data = '0; adc_b_data = '0; trig_level = '0;
        repeat (3) tick();
        check("rst pwdn", adc_pwdn, 1);
        check("rst ready", ready, 0);
        check("rst flags", {out_valid, out_last, frame_done, overrun}, 4'b0000);
        check("rst data", out_data, 0);

        rst = 1'b0;
        cyc = 0;
        repeat (10) tick();
        check("pre_lock pwdn", adc_pwdn, 1);
        check("pre_lock ready", ready, 0);
        lock_sequence("lock");

        // free-run ramp with a start pulse mid-frame that must be ignored
        for (int i = 0; i < 512; i++) begin
            pa[i] = W'(i + 5); pb[i] = 12'hFFF - W'(i + 5); rdy_pat[i] = 1'b1;
        end
        run_frame("ramp", 50, n, fd, ov);
        check("ramp n_words", n, FL);
        check("ramp done_rel", fd, FL + 2);
        check("ramp overrun", ov, 0);

        for (int i = 100; i < 105; i++) rdy_pat[i] = 1'b0;
        run_frame("bp", 150, n, fd, ov);
        check("bp n_words", n, FL - 5);
        check("bp done_rel", fd, FL + 2);
        check("bp overrun", ov, 1);

        for (int f = 0; f < 6; f++) begin
            pct = (f < 2) ? 100 : ((f < 4) ? 85 : 55);
            for (int i = 0; i < 512; i++) begin
                pa[i] = W'($urandom);
                pb[i] = W'($urandom);
                rdy_pat[i] = (i >= 300) || ($urandom_range(0, 99) < pct);
            end
            run_frame($sformatf("rnd%0d", f), $urandom_range(3, 250), n, fd, ov);
        end

        out_ready = 1'b1;
        for (int r = 0; r < 7; r++) trig_row(r);

        // lock loss at sample ~100 after an early overrun
        base = 12'h100;
        for (int i = 0; i < 512; i++) begin
            pa[i] = W'(base + i); pb[i] = W'(i); rdy_pat[i] = !(i == 20 || i == 21);
        end
        start = 1'b1; trig_en = 1'b0; out_ready = 1'b1;
        adc_a_data = pa[0]; adc_b_data = pb[0];
        for (int rel = 1; rel <= 104; rel++) begin
            tick();
            start = 1'b0;
            out_ready = rdy_pat[rel];
            adc_a_data = pa[rel]; adc_b_data = pb[rel];
            if (rel == 101) pll_lock = 1'b0;
        end
        check("ll out_valid", out_valid, 0);
        check("ll pwdn", adc_pwdn, 1);
        check("ll overrun_held", overrun, 1);
        check("ll out_last", out_last, 0);
        act = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            act += int'(frame_done) + int'(out_valid) + int'(out_last) + int'(ready);
        end
        check("ll quiet", act, 0);
        check("ll overrun_still", overrun, 1);
        lock_sequence("relock");
        start = 1'b1; trig_en = 1'b0; out_ready = 1'b1;
        tick();
        start = 1'b0;
        tick();
        check("ovr cleared", overrun, 0);
        wait_done("after_relock");

        // asynchronous reset in the middle of a frame
        repeat (2) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (50) tick();
        check("pre_rst valid", out_valid, 1);
        #10;
        rst = 1'b1;
        #1;
        check("async valid", out_valid, 0);
        check("async data", out_data, 0);
        check("async pwdn", adc_pwdn, 1);
        check("async ready", ready, 0);
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
